adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
// - Parametrised, pipelined successor to the JAM-1 8-bit combinational ALU adder.
// - Adds LHS + RHS + selected carry-in and produces the sum plus C/Z/V/N flags.
// - The carry chain is split into SEG-bit segments, one register stage per segment.
// - Uses valid/ready handshakes on both sides.
// - Sits between the ALU operand latch and the flags/writeback stage of wider datapaths.
// PARAMETERS
// - WIDTH  8  operand and result width in bits; WIDTH >= 2.
// - SEG    4  bits added per pipeline stage; WIDTH % SEG must be 0, else elaboration $error.
// - STAGES = WIDTH/SEG (localparam): pipeline depth and latency in cycles.
// PORTS
// - clk            in   1      single clock; all state on rising edge
// - rst            in   1      synchronous, active-high reset
// - in_valid       in   1      operands and carry controls are valid
// - in_ready       out  1      block accepts the operation this cycle
// - lhs            in   WIDTH  left operand
// - rhs            in   WIDTH  right operand
// - carry_sel      in   2      carry-in select (encodings in alu_pkg)
// - carry_flag     in   1      architectural carry flag, sampled on accept
// - out_valid      out  1      result and flags are valid
// - out_ready      in   1      consumer accepts the result this cycle
// - sum            out  WIDTH  (lhs + rhs + cin) mod 2^WIDTH
// - carry_out      out  1      carry out of bit WIDTH-1
// - zero           out  1      sum == 0
// - overflow       out  1      signed overflow: lhs[MSB]==rhs[MSB] && sum[MSB]!=lhs[MSB]
// - negative       out  1      sum[MSB]
// BEHAVIOUR
// - Reset: every stage-valid bit and out_valid = 0; sum and all flags = 0.
// - in_ready = 1 during reset cycle = 0 is NOT used: in_ready = !rst && advance.
// - advance = !out_valid || out_ready; the whole pipeline shifts one stage when advance = 1.
// - Accept: in_valid && in_ready. No accept while rst is high.
// - Carry-in select, resolved at accept:
//     - CSEL_ZERO (00): cin = 0
//     - CSEL_ONE (01): cin = 1
//     - CSEL_FLAG (10): cin = carry_flag
//     - CSEL_NFLAG (11): cin = ~carry_flag (borrow form, for SBC)
// - Stage k adds bits [k*SEG +: SEG] using the registered carry from stage k-1.
// - Upper operand bits and already-computed low sum bits travel forward registered.
// - Latency: result reaches out_valid exactly STAGES cycles after accept, given advance every cycle.
// - Throughput: one operation per cycle.
// - Back-pressure: when out_valid && !out_ready, all stages hold, outputs stay stable, and in_ready = 0.
// - No op is lost, duplicated or reordered under back-pressure.
// - Bubbles: empty stages are not compressed while stalled. Stage valid bits shift with the data.
// - Flags: computed from the full sum in the final stage and registered together with sum.
//     - Z is computed over all WIDTH bits.
//     - V uses operand MSBs carried forward.
// - Simultaneous pop and push: when out_ready = 1 and in_valid = 1, both occur in the same cycle.
// - Reset mid-operation: all in-flight ops are discarded and out_valid = 0 the cycle after rst.
// - Wrap-around: sum is modulo 2^WIDTH; carry_out reports the discarded bit.
// STRUCTURE
// - alu_pkg: CSEL_ZERO/ONE/FLAG/NFLAG localparams (2-bit) and the carry_sel_t typedef.
// - Sub-module adder_seg (param SEG): combinational SEG-bit add, inputs cin, outputs sum and cout.
//     - Instantiated STAGES times by a generate loop.
//     - Stage registers and the handshake live in adder_pipe.
// TESTING
// - W8/S4, 0xFF+0x01, CSEL_ZERO -> 2 cycles later: sum=0x00, C=1, Z=1, V=0, N=0.
// - W8/S4, 0x7F+0x01, CSEL_ZERO -> sum=0x80, C=0, V=1, N=1, Z=0.
// - W8/S4, 0x10+0x20: CSEL_FLAG with carry_flag=1 -> 0x31.
// - W8/S4, 0x10+0x20: CSEL_NFLAG with carry_flag=1 -> 0x30.
// - Stream 6 ops back-to-back and hold out_ready=0 for 5 cycles mid-stream:
//     - in_ready drops.
//     - All 6 results emerge in order, with no loss or duplication and stable outputs while stalled.
// - Assert rst with 2 ops in flight -> out_valid=0 next cycle; the old results are never seen.
//     - First op after reset emerges after STAGES cycles.
// - W16/S4, 0xFFFF+0x0000, CSEL_ONE -> after exactly 4 cycles: sum=0x0000, C=1, Z=1.
//     - The carry ripples across all 4 stages.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - carry-in select encodings shared by the ALU datapath
package alu_pkg;

    typedef logic [1:0] carry_sel_t;

    localparam carry_sel_t CSEL_ZERO  = 2'b00;
    localparam carry_sel_t CSEL_ONE   = 2'b01;
    localparam carry_sel_t CSEL_FLAG  = 2'b10;
    localparam carry_sel_t CSEL_NFLAG = 2'b11;

    // NFLAG is the borrow form used by subtract-with-carry.
    function automatic logic resolveCin(carry_sel_t sel, logic carryFlag);
        logic cin;
        case (sel)
            CSEL_ZERO: cin = 1'b0;
            CSEL_ONE:  cin = 1'b1;
            CSEL_FLAG: cin = carryFlag;
            default:   cin = ~carryFlag;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - combinational SEG-bit adder slice with carry in/out
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - segmented pipelined adder with C/Z/V/N flags and valid/ready handshakes
module adder_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic [1:0]       carry_sel,
    input  logic             carry_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             negative
);

    localparam int STAGES = WIDTH / SEG;
    localparam int MSB    = WIDTH - 1;

    if (WIDTH < 2) begin : gBadWidth
        $error("adder_pipe: WIDTH must be at least 2");
    end
    if (WIDTH % SEG != 0) begin : gBadSeg
        $error("adder_pipe: WIDTH must be a multiple of SEG");
    end

    // Stage registers: operands travel forward whole, sum fills in one segment per stage.
    logic             vldR    [STAGES];
    logic [WIDTH-1:0] lhsR    [STAGES];
    logic [WIDTH-1:0] rhsR    [STAGES];
    logic [WIDTH-1:0] sumR    [STAGES];
    logic             cyR     [STAGES];
    logic             zeroR;
    logic             ovfR;
    logic             negR;

    // Values presented to the adder slice of each stage.
    logic             stVld   [STAGES];
    logic [WIDTH-1:0] stLhs   [STAGES];
    logic [WIDTH-1:0] stRhs   [STAGES];
    logic [WIDTH-1:0] stSum   [STAGES];
    logic             stCin   [STAGES];
    logic [WIDTH-1:0] nextSum [STAGES];
    logic             segCout [STAGES];

    logic             advance;
    logic [WIDTH-1:0] fullSum;
    logic             zeroNext;
    logic             ovfNext;
    logic             negNext;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !rst && advance;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic [SEG-1:0]   segSum;
        logic [WIDTH-1:0] merged;

        if (k == 0) begin : gHead
            assign stVld[k] = in_valid;
            assign stLhs[k] = lhs;
            assign stRhs[k] = rhs;
            assign stSum[k] = '0;
            assign stCin[k] = resolveCin(carry_sel, carry_flag);
        end else begin : gBody
            assign stVld[k] = vldR[k-1];
            assign stLhs[k] = lhsR[k-1];
            assign stRhs[k] = rhsR[k-1];
            assign stSum[k] = sumR[k-1];
            assign stCin[k] = cyR[k-1];
        end

        adder_seg #(
            .SEG (SEG)
        ) uSeg (
            .a    (stLhs[k][k*SEG +: SEG]),
            .b    (stRhs[k][k*SEG +: SEG]),
            .cin  (stCin[k]),
            .sum  (segSum),
            .cout (segCout[k])
        );

        always_comb begin
            merged = stSum[k];
            merged[k*SEG +: SEG] = segSum;
        end

        assign nextSum[k] = merged;
    end

    // Flags come from the completed sum of the last stage and are registered alongside it.
    assign fullSum  = nextSum[STAGES-1];
    assign zeroNext = (fullSum == '0);
    assign negNext  = fullSum[MSB];
    assign ovfNext  = (stLhs[STAGES-1][MSB] == stRhs[STAGES-1][MSB]) &&
                      (fullSum[MSB] != stLhs[STAGES-1][MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vldR[k] <= 1'b0;
                lhsR[k] <= '0;
                rhsR[k] <= '0;
                sumR[k] <= '0;
                cyR[k]  <= 1'b0;
            end
            zeroR <= 1'b0;
            ovfR  <= 1'b0;
            negR  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vldR[k] <= stVld[k];
                lhsR[k] <= stLhs[k];
                rhsR[k] <= stRhs[k];
                sumR[k] <= nextSum[k];
                cyR[k]  <= segCout[k];
            end
            zeroR <= zeroNext;
            ovfR  <= ovfNext;
            negR  <= negNext;
        end
    end

    assign out_valid = vldR[STAGES-1];
    assign sum       = sumR[STAGES-1];
    assign carry_out = cyR[STAGES-1];
    assign zero      = zeroR;
    assign overflow  = ovfR;
    assign negative  = negR;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe at 8/4 and 16/4
module tb_adder_pipe;
    import alu_pkg::*;

    localparam int W8   = 8;
    localparam int W16  = 16;
    localparam int SEG  = 4;
    localparam int ST8  = W8 / SEG;
    localparam int ST16 = W16 / SEG;

    typedef struct {
        logic [15:0] sum;
        logic        c, z, v, n;
        int          acc;
        bit          chkLat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   passCnt = 0;
    int   totalCnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv8, ir8, flag8, ov8, or8, c8, z8, v8, n8;
    logic [7:0]  lhs8, rhs8, sum8;
    logic [1:0]  sel8;
    logic        iv16, ir16, flag16, ov16, or16, c16, z16, v16, n16;
    logic [15:0] lhs16, rhs16, sum16;
    logic [1:0]  sel16;

    adder_pipe #(.WIDTH(W8), .SEG(SEG)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .lhs(lhs8), .rhs(rhs8),
        .carry_sel(sel8), .carry_flag(flag8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .carry_out(c8), .zero(z8), .overflow(v8), .negative(n8));

    adder_pipe #(.WIDTH(W16), .SEG(SEG)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .lhs(lhs16), .rhs(rhs16),
        .carry_sel(sel16), .carry_flag(flag16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .carry_out(c16), .zero(z16), .overflow(v16), .negative(n16));

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference: plain integer arithmetic, signed overflow judged by range.
    function automatic exp_t refAdd(int w, longint a, longint b, logic [1:0] sel, logic flag,
                                    int acc, bit chkLat);
        exp_t e;
        longint cin, full, modv, half, sa, sb, ss;
        case (sel)
            CSEL_ZERO: cin = 0;
            CSEL_ONE:  cin = 1;
            CSEL_FLAG: cin = flag ? 1 : 0;
            default:   cin = flag ? 0 : 1;
        endcase
        modv = longint'(1) << w;
        half = modv / 2;
        full = a + b + cin;
        e.sum = 16'(full % modv);
        e.c = (full >= modv);
        e.z = ((full % modv) == 0);
        e.n = ((full % modv) >= half);
        sa = (a >= half) ? a - modv : a;
        sb = (b >= half) ? b - modv : b;
        ss = sa + sb + cin;
        e.v = (ss >= half) || (ss < -half);
        e.acc = acc;
        e.chkLat = chkLat;
        return e;
    endfunction

    exp_t        q8[$];
    exp_t        q16[$];
    bit          lat8 = 1'b0;
    bit          prevStall8 = 1'b0;
    logic [11:0] prevOut8 = '0;
    int          stallCyc8 = 0;
    int          readyMode = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q8.delete();
            prevStall8 = 1'b0;
        end else begin
            check("in_ready8", 32'(ir8), 32'(!ov8 || or8));
            if (prevStall8) begin
                check("hold_valid8", 32'(ov8), 1);
                check("hold_out8", 32'({sum8, c8, z8, v8, n8}), 32'(prevOut8));
            end
            if (ov8 && !or8) stallCyc8++;
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    totalCnt++;
                    $display("FAIL unexpected_out8: got sum %0h, expected no output", sum8);
                end else begin
                    e = q8.pop_front();
                    check("sum8", 32'(sum8), 32'(e.sum[7:0]));
                    check("flags8_czvn", 32'({c8, z8, v8, n8}), 32'({e.c, e.z, e.v, e.n}));
                    if (e.chkLat) check("latency8", cyc - e.acc, ST8);
                end
            end
            prevStall8 = ov8 && !or8;
            prevOut8 = {sum8, c8, z8, v8, n8};
            if (iv8 && ir8)
                q8.push_back(refAdd(W8, longint'(lhs8), longint'(rhs8), sel8, flag8, cyc, lat8));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q16.delete();
        end else begin
            if (ov16) begin
                if (q16.size() == 0) begin
                    totalCnt++;
                    $display("FAIL unexpected_out16: got sum %0h, expected no output", sum16);
                end else begin
                    e = q16.pop_front();
                    check("sum16", 32'(sum16), 32'(e.sum));
                    check("flags16_czvn", 32'({c16, z16, v16, n16}), 32'({e.c, e.z, e.v, e.n}));
                    check("latency16", cyc - e.acc, ST16);
                end
            end
            if (iv16 && ir16)
                q16.push_back(refAdd(W16, longint'(lhs16), longint'(rhs16), sel16, flag16, cyc, 1'b1));
        end
    end

    initial begin
        or8 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                1:       or8 = 1'($urandom_range(0, 1));
                2:       or8 = 1'b0;
                default: or8 = 1'b1;
            endcase
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s, input logic f);
        int n = 0;
        lhs8 = a; rhs8 = b; sel8 = s; flag8 = f; iv8 = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ir8 && n < 40);
        if (!ir8) check("accept_timeout8", 32'(ir8), 1);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s, input logic f);
        int n = 0;
        lhs16 = a; rhs16 = b; sel16 = s; flag16 = f; iv16 = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ir16 && n < 40);
        if (!ir16) check("accept_timeout16", 32'(ir16), 1);
        @(posedge clk);
        #1;
        iv16 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("drain8", q8.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("drain16", q16.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        iv8 = 0; lhs8 = '0; rhs8 = '0; sel8 = CSEL_ZERO; flag8 = 0;
        iv16 = 0; lhs16 = '0; rhs16 = '0; sel16 = CSEL_ZERO; flag16 = 0; or16 = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready8", 32'(ir8), 0);
        check("rst_out_valid8", 32'(ov8), 0);
        check("rst_outputs8", 32'({sum8, c8, z8, v8, n8}), 0);
        check("rst_outputs16", 32'({ov16, sum16, c16, z16, v16, n16}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst8", 32'(ir8), 1);
        @(posedge clk);
        #1;

        lat8 = 1'b1;
        issue8(8'hFF, 8'h01, CSEL_ZERO, 1'b0);
        issue8(8'h7F, 8'h01, CSEL_ZERO, 1'b0);
        issue8(8'h10, 8'h20, CSEL_FLAG, 1'b1);
        issue8(8'h10, 8'h20, CSEL_NFLAG, 1'b1);
        issue8(8'h80, 8'h80, CSEL_ZERO, 1'b0);
        issue8(8'h00, 8'hFF, CSEL_ONE, 1'b0);
        drain8();

        lat8 = 1'b0;
        readyMode = 1;
        repeat (40) issue8(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        readyMode = 0;
        drain8();

        s0 = stallCyc8;
        fork
            for (int i = 0; i < 6; i++)
                issue8(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            begin
                repeat (3) @(posedge clk);
                readyMode = 2;
                repeat (5) @(posedge clk);
                readyMode = 0;
            end
        join
        drain8();
        check("stall_cycles8", stallCyc8 - s0, 5);

        issue8(8'h11, 8'h22, CSEL_ZERO, 1'b0);
        issue8(8'h33, 8'h44, CSEL_ONE, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_valid8", 32'(ov8), 0);
        check("rst_flush_sum8", 32'(sum8), 0);
        repeat (4) @(posedge clk);
        #1;
        lat8 = 1'b1;
        issue8(8'h05, 8'h06, CSEL_ONE, 1'b0);
        drain8();

        issue16(16'hFFFF, 16'h0000, CSEL_ONE, 1'b0);
        issue16(16'h7FFF, 16'h0000, CSEL_FLAG, 1'b1);
        repeat (12) issue16(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        drain16();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
